// File: rtl/pwm_seq_multi.sv
// pwm_seq_multi: multi-channel PWM player stepping through samples held in memory.
// Define PWM_DEADBAND_EN to blank spd for one period whenever a channel reverses dir.
module pwm_seq_multi #(
   parameter int NUM_CH           = 2,
   parameter int DUTY_W           = 8,
   parameter int ADDR_W           = 8,
   parameter int TICK_DIV         = 250,
   parameter int PERIODS_PER_STEP = 13
) (
   input  logic                   CLK100MHZ,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   wrap_en,
   input  logic [ADDR_W-1:0]      last_addr,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_rd,
   input  logic [16*NUM_CH-1:0]   mem_data,
   output logic [NUM_CH-1:0]      spd,
   output logic [NUM_CH-1:0]      dir,
   output logic                   step_stb,
   output logic                   done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(PERIODS_PER_STEP);
   localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] PER_TOP = SW'(PERIODS_PER_STEP - 1);
   localparam logic [DUTY_W-1:0] CNT_TOP = {{(DUTY_W-1){1'b1}}, 1'b0};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD0 = 3'd1;
   localparam logic [2:0] S_PRIME = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]                    state;
   logic [PW-1:0]                 pre_cnt;
   logic [DUTY_W-1:0]             pwm_cnt;
   logic [SW-1:0]                 per_cnt;
   logic                          rd_pend;
   logic [ADDR_W-1:0]             act_addr;
   logic [ADDR_W-1:0]             nxt_addr;
   logic [NUM_CH-1:0][DUTY_W-1:0] act_duty;
   logic [NUM_CH-1:0][DUTY_W-1:0] stg_duty;
   logic [NUM_CH-1:0][DUTY_W-1:0] new_duty;
   logic [NUM_CH-1:0]             act_dir;
   logic [NUM_CH-1:0]             stg_dir;
   logic [NUM_CH-1:0]             new_dir;
   logic [NUM_CH-1:0]             spd_mask;
   logic                          tick;
   logic                          per_end;
   logic                          step_end;
   logic                          last_step;
   logic                          unused_bits;

   always_comb begin
      new_duty = '0;
      new_dir  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         new_duty[c] = mem_data[16*c +: DUTY_W];
         new_dir[c]  = mem_data[16*c + 15];
      end
   end

   assign unused_bits = ^mem_data;
   assign tick      = (pre_cnt == PRE_TOP);
   assign per_end   = tick && (pwm_cnt == CNT_TOP);
   assign step_end  = per_end && (per_cnt == PER_TOP);
   assign last_step = (act_addr == last_addr) && !wrap_en;
   assign nxt_addr  = (mem_addr == last_addr) ? '0 : mem_addr + 1'b1;

`ifdef PWM_DEADBAND_EN
   logic [NUM_CH-1:0] blank;

   // blank covers exactly the first period of a step whose dir flipped
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         blank <= '0;
      end else if (!en || state != S_RUN) begin
         blank <= '0;
      end else if (step_end && !last_step) begin
         blank <= stg_dir ^ act_dir;
      end else if (per_end) begin
         blank <= '0;
      end
   end

   assign spd_mask = ~blank;
`else
   assign spd_mask = '1;
`endif

   always_comb begin
      spd = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         spd[c] = (state == S_RUN) && spd_mask[c] &&
                  (pwm_cnt < act_duty[c]);
      end
   end

   assign dir  = (state == S_RUN) ? act_dir : '0;
   assign done = (state == S_DONE);

   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         pre_cnt  <= '0;
         pwm_cnt  <= '0;
         per_cnt  <= '0;
         rd_pend  <= 1'b0;
         mem_addr <= '0;
         mem_rd   <= 1'b0;
         step_stb <= 1'b0;
         act_addr <= '0;
         act_duty <= '0;
         act_dir  <= '0;
         stg_duty <= '0;
         stg_dir  <= '0;
      end else begin
         step_stb <= 1'b0;
         mem_rd   <= 1'b0;
         rd_pend  <= mem_rd;
         if (!en && state != S_IDLE) begin
            state    <= S_IDLE;
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            per_cnt  <= '0;
            rd_pend  <= 1'b0;
            mem_addr <= '0;
            act_addr <= '0;
            act_duty <= '0;
            act_dir  <= '0;
            stg_duty <= '0;
            stg_dir  <= '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (en) begin
                     state    <= S_LOAD0;
                     mem_addr <= '0;
                     mem_rd   <= 1'b1;
                  end
               end
               S_LOAD0: state <= S_PRIME;
               S_PRIME: begin
                  act_duty <= new_duty;
                  act_dir  <= new_dir;
                  act_addr <= mem_addr;
                  step_stb <= 1'b1;
                  pre_cnt  <= '0;
                  pwm_cnt  <= '0;
                  per_cnt  <= '0;
                  mem_addr <= nxt_addr;
                  mem_rd   <= 1'b1;
                  state    <= S_RUN;
               end
               S_RUN: begin
                  if (rd_pend) begin
                     stg_duty <= new_duty;
                     stg_dir  <= new_dir;
                  end
                  pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                  if (tick) pwm_cnt <= per_end ? '0 : pwm_cnt + 1'b1;
                  if (per_end) per_cnt <= step_end ? '0 : per_cnt + 1'b1;
                  // mem_addr holds the address of the staged sample here
                  if (step_end) begin
                     if (last_step) begin
                        state <= S_DONE;
                     end else begin
                        act_duty <= stg_duty;
                        act_dir  <= stg_dir;
                        act_addr <= mem_addr;
                        step_stb <= 1'b1;
                        mem_addr <= nxt_addr;
                        mem_rd   <= 1'b1;
                     end
                  end
               end
               S_DONE: state <= S_DONE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
